// File: rtl/systol_pkg.sv
// rtl/systol_pkg.sv - shared constants, state encoding and lane type for the systolic array
package systol_pkg;

  localparam int N  = 3;
  localparam int DW = 5;
  localparam int AW = $clog2(N);

  // ld_sel encoding
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  // One operand per lane, lane 0 in the low bits
  typedef logic [N-1:0][DW-1:0] lane_t;

endpackage

// File: rtl/systol_opbuf.sv
// rtl/systol_opbuf.sv - dual NxN operand register file with skewed per-lane read muxes
module systol_opbuf #(
  parameter int N  = systol_pkg::N,
  parameter int DW = systol_pkg::DW,
  parameter int AW = $clog2(N),
  parameter int TW = $clog2(2*N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [AW-1:0]          wr_row,
  input  logic [AW-1:0]          wr_col,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  input  logic [TW-1:0]          rd_step,
  output logic [N-1:0][DW-1:0]   rd_left,
  output logic [N-1:0][DW-1:0]   rd_top
);
  import systol_pkg::*;

  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d;
  logic [N-1:0][N-1:0][DW-1:0] b_q, b_d;

  // Single write port: the caller has already range-checked the indices
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_en) begin
      if (wr_sel == SEL_B) begin
        b_d[wr_row][wr_col] = wr_data;
      end else begin
        a_d[wr_row][wr_col] = wr_data;
      end
    end
  end

  // Operand storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Lane i reads element k = step - i; lanes outside the wavefront read zero
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [TW-1:0] k;
    logic          hit;
    assign k          = rd_step - TW'(i);
    assign hit        = rd_en && (rd_step >= TW'(i)) && (k < TW'(N));
    assign rd_left[i] = hit ? a_q[i][k[AW-1:0]] : '0;
    assign rd_top[i]  = hit ? b_q[k[AW-1:0]][i] : '0;
  end

endmodule

// File: rtl/systol_ctrl.sv
// rtl/systol_ctrl.sv - operand load port, pass sequencer and skewed wavefront driver for systol
module systol_ctrl #(
  parameter int N  = systol_pkg::N,
  parameter int DW = systol_pkg::DW,
  parameter int AW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [AW-1:0]        ld_row,
  input  logic [AW-1:0]        ld_col,
  input  logic [DW-1:0]        ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 ld_err,
  output logic                 arr_clr,
  output logic [N-1:0][DW-1:0] left,
  output logic [N-1:0][DW-1:0] top
);
  import systol_pkg::*;

  localparam int TW = $clog2(2*N);

  state_e                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  wr_en;
  logic                  ld_err_d;
  logic                  busy_q, done_q, ld_err_q, arr_clr_q;
  logic [N-1:0][DW-1:0]  left_q, top_q;
  logic [N-1:0][DW-1:0]  feed_left, feed_top;

  // Loads only land while idle and in range; anything else is reported next cycle
  assign wr_en    = ld_en && (state_q == S_IDLE)
                    && ({1'b0, ld_row} < (AW+1)'(N))
                    && ({1'b0, ld_col} < (AW+1)'(N));
  assign ld_err_d = ld_en && !wr_en;

  // Next state and step counter; outputs are registered from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == TW'(2*N-2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == TW'(N-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  systol_opbuf #(
    .N  (N),
    .DW (DW),
    .AW (AW),
    .TW (TW)
  ) u_opbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (ld_sel),
    .wr_row  (ld_row),
    .wr_col  (ld_col),
    .wr_data (ld_data),
    .rd_en   (state_d == S_FEED),
    .rd_step (cnt_d),
    .rd_left (feed_left),
    .rd_top  (feed_top)
  );

  // Sequencer state and registered outputs; reset holds the array accumulators clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_err_q  <= 1'b0;
      arr_clr_q <= 1'b1;
      left_q    <= '0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      ld_err_q  <= ld_err_d;
      arr_clr_q <= (state_d == S_CLEAR);
      left_q    <= feed_left;
      top_q     <= feed_top;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ld_err  = ld_err_q;
  assign arr_clr = arr_clr_q;
  assign left    = left_q;
  assign top     = top_q;

endmodule
